// File: rtl/coco_sd_pkg.sv
// -----------------------------------------------------------------------------
// coco_sd_pkg
// Shared definitions for the SD block responder: drive count, block size,
// responder FSM state encoding and a small one-hot to index helper.
// -----------------------------------------------------------------------------
package coco_sd_pkg;

  localparam int NUM_DRIVES = 4;
  localparam int BLK_BYTES  = 512;

  // Requester buffer data is valid two cycles after the buffer address moves;
  // the write path waits through counts 0..DIN_WAIT_LAST before sampling.
  localparam logic [1:0] DIN_WAIT_LAST = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RD_FETCH,
    RD_PUSH,
    WR_ADDR,
    WR_WAIT,
    WR_STORE,
    DONE
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_DRIVES-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
// Four-way round-robin arbiter. The search starts at the drive just after
// the last-served one, so the last-served drive has the lowest priority.
//
// Ports
//   req   in  4  request vector, one bit per drive
//   last  in  2  index of the drive served most recently
//   grant out 4  one-hot grant, zero when no request is pending
// -----------------------------------------------------------------------------
module rr_arb4
  import coco_sd_pkg::*;
(
  input  logic [NUM_DRIVES-1:0] req,
  input  logic [1:0]            last,
  output logic [NUM_DRIVES-1:0] grant
);

  // NOTE: every output of a combinational block is assigned a default first,
  // so no path through the block leaves it holding a value (no latch).
  always_comb begin
    grant = '0;
    // Walk from the farthest candidate (last itself) to the nearest
    // (last+1); the nearest pending request is written last and wins.
    for (int i = NUM_DRIVES; i >= 1; i--) begin
      if (req[last + 2'(i)]) begin
        grant                = '0;
        grant[last + 2'(i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_blk_responder.sv
// -----------------------------------------------------------------------------
// sd_blk_responder
// Serves block read/write requests from four virtual SD drives against a
// byte-wide backing memory. One drive is served at a time; the requester's
// block buffer is filled (read) or drained (write) one byte per step.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   sd_lba[4]           per-drive block address
//   sd_blk_cnt[4]       per-drive block count minus one (clamped to 31)
//   sd_rd, sd_wr        per-drive request levels (read wins if both set)
//   sd_ack              one-hot acknowledge, high for the whole transfer
//   sd_buff_addr        byte index within the current block
//   sd_buff_dout        read data towards the requester buffer
//   sd_buff_wr          one-cycle write strobe for sd_buff_dout
//   sd_buff_din[4]      requester buffer data (2-cycle latency from addr)
//   img_size[4]         mounted image size in bytes, 0 = no image
//   mem_addr            backing memory address {drive, offset[19:0]}
//   mem_rd, mem_wr      memory strobes, held until mem_ready
//   mem_wdata           memory write data
//   mem_rdata           memory read data, valid with mem_ready
//   mem_ready           one-cycle completion of the pending strobe
//   busy                high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module sd_blk_responder
  import coco_sd_pkg::*;
#(
  parameter int BLKSZ  = 2,
  parameter int MEM_AW = 22
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           sd_lba      [NUM_DRIVES],
  input  logic [5:0]            sd_blk_cnt  [NUM_DRIVES],
  input  logic [NUM_DRIVES-1:0] sd_rd,
  input  logic [NUM_DRIVES-1:0] sd_wr,
  output logic [NUM_DRIVES-1:0] sd_ack,
  output logic [8:0]            sd_buff_addr,
  output logic [7:0]            sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [7:0]            sd_buff_din [NUM_DRIVES],
  input  logic [19:0]           img_size    [NUM_DRIVES],
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  // Byte offset of a block inside its image.
  localparam int BLK_SHIFT = BLKSZ + 7;

  state_t                state;
  logic [1:0]            drive_q;
  logic [1:0]            rr_last;
  logic [31:0]           lba_q;
  logic [4:0]            cnt_q;
  logic [13:0]           byte_cnt;   // up to 32 blocks of 512 bytes
  logic [1:0]            wait_cnt;

  logic [NUM_DRIVES-1:0] req;
  logic [NUM_DRIVES-1:0] grant;
  logic [1:0]            grant_idx;
  logic [5:0]            cnt_sel;
  logic [4:0]            cnt_clamped;
  logic [19:0]           lba_off;
  logic [19:0]           offset;
  logic                  in_range;
  logic                  last_byte;
  logic [MEM_AW-1:0]     mem_addr_next;

  assign req = sd_rd | sd_wr;

  rr_arb4 u_arb (
    .req   (req),
    .last  (rr_last),
    .grant (grant)
  );

  assign grant_idx   = onehot_to_idx(grant);
  assign cnt_sel     = sd_blk_cnt[grant_idx];
  assign cnt_clamped = cnt_sel[5] ? 5'd31 : cnt_sel[4:0];

  // Image offset wraps at 20 bits; anything at or past the image end never
  // touches memory.
  assign lba_off       = 20'(lba_q << BLK_SHIFT);
  assign offset        = lba_off + 20'(byte_cnt);
  assign in_range      = (offset < img_size[drive_q]);
  assign last_byte     = (byte_cnt == 14'(((int'(cnt_q) + 1) * BLK_BYTES) - 1));
  assign mem_addr_next = MEM_AW'({drive_q, offset});

  // NOTE: state and registered outputs use non-blocking assignments only, so
  // every right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and covers every register here; there is no
    // storage array, so nothing is left un-reset.
    if (RESET) begin
      state        <= IDLE;
      busy         <= 1'b0;
      sd_ack       <= '0;
      sd_buff_wr   <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rr_last      <= 2'd3;
      drive_q      <= 2'd0;
      lba_q        <= '0;
      cnt_q        <= '0;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            busy  <= 1'b1;
          end
        end

        // Requests are re-sampled here; if they vanished since IDLE, go back.
        GRANT: begin
          if (|req) begin
            drive_q  <= grant_idx;
            rr_last  <= grant_idx;
            lba_q    <= sd_lba[grant_idx];
            cnt_q    <= cnt_clamped;
            byte_cnt <= '0;
            sd_ack   <= grant;
            state    <= sd_rd[grant_idx] ? RD_FETCH : WR_ADDR;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        // First cycle issues the read (or substitutes zero when out of
        // range); later cycles wait on mem_ready with mem_rd held.
        RD_FETCH: begin
          if (!mem_rd) begin
            if (in_range) begin
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr_next;
            end else begin
              sd_buff_dout <= 8'h00;
              sd_buff_addr <= byte_cnt[8:0];
              sd_buff_wr   <= 1'b1;
              state        <= RD_PUSH;
            end
          end else if (mem_ready) begin
            mem_rd       <= 1'b0;
            sd_buff_dout <= mem_rdata;
            sd_buff_addr <= byte_cnt[8:0];
            sd_buff_wr   <= 1'b1;
            state        <= RD_PUSH;
          end
        end

        RD_PUSH: begin
          sd_buff_wr <= 1'b0;
          byte_cnt   <= byte_cnt + 14'd1;
          state      <= last_byte ? DONE : RD_FETCH;
        end

        WR_ADDR: begin
          sd_buff_addr <= byte_cnt[8:0];
          wait_cnt     <= '0;
          state        <= WR_WAIT;
        end

        WR_WAIT: begin
          if (wait_cnt == DIN_WAIT_LAST) begin
            state <= WR_STORE;
            if (in_range) begin
              mem_wr    <= 1'b1;
              mem_wdata <= sd_buff_din[drive_q];
              mem_addr  <= mem_addr_next;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        // With mem_wr low the byte was out of range and is dropped at once.
        WR_STORE: begin
          if (!mem_wr || mem_ready) begin
            mem_wr   <= 1'b0;
            byte_cnt <= byte_cnt + 14'd1;
            state    <= last_byte ? DONE : WR_ADDR;
          end
        end

        DONE: begin
          sd_ack <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_blk_responder.sv
// -----------------------------------------------------------------------------
// tb_sd_blk_responder
// Scenario tasks drive requests and compare the DUT's buffer/memory traffic
// against expectations pushed into scoreboard queues up front.
// Memory model: mem_rdata = mem_addr[7:0], one-cycle ready, optional stall.
// Requester buffer model: sd_buff_din = sd_buff_addr[7:0]^0x5A, 2-cycle latency.
// -----------------------------------------------------------------------------
module tb_sd_blk_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] sd_lba      [4];
  logic [5:0]  sd_blk_cnt  [4];
  logic [3:0]  sd_rd, sd_wr;
  logic [3:0]  sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din [4];
  logic [19:0] img_size    [4];
  logic [21:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic        busy;

  logic        stall = 1'b0;
  logic [7:0]  din_p1 = 8'h00;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb_q[$];
  logic [21:0] maddr_q[$];
  int          gnt_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 CLK = ~CLK;

  sd_blk_responder #(.BLKSZ(2), .MEM_AW(22)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .img_size     (img_size),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .busy         (busy)
  );

  // Backing memory: answers a held strobe with a one-cycle ready pulse.
  always @(negedge CLK) begin
    if ((mem_rd === 1'b1 || mem_wr === 1'b1) && !mem_ready && !stall) begin
      mem_ready = 1'b1;
      mem_rdata = mem_addr[7:0];
    end else begin
      mem_ready = 1'b0;
    end
  end

  // Requester buffers: data follows the address after a two-stage delay.
  always @(negedge CLK) begin
    for (int d = 0; d < 4; d++) sd_buff_din[d] = din_p1;
    din_p1 = sd_buff_addr[7:0] ^ 8'h5A;
  end

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (sd_ack !== 4'h0) begin
      n_fail++; $display("FAIL reset_ack: got %b want 0000", sd_ack);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_checks++;
    if ({mem_rd, mem_wr, sd_buff_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {mem_rd, mem_wr, sd_buff_wr});
    end
    n_checks++;
    if ({sd_buff_addr, sd_buff_dout} !== 17'h0) begin
      n_fail++; $display("FAIL reset_buff: got addr=%h dout=%h want 0", sd_buff_addr, sd_buff_dout);
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 30'h0) begin
      n_fail++; $display("FAIL reset_mem: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b want 0 with no request", busy);
    end
  endtask

  task automatic test_read_single();
    exp_t        e;
    logic [21:0] a;
    logic        prev_rd = 1'b0;
    sb_q.delete(); maddr_q.delete();
    sd_lba[0] = 32'd2; sd_blk_cnt[0] = 6'd0; img_size[0] = 20'd368640;
    for (int i = 0; i < 512; i++) begin
      e.addr = 22'(i);
      e.data = 8'((32'h400 + i) & 32'hFF);
      sb_q.push_back(e);
      maddr_q.push_back({2'b00, 20'(32'h400 + i)});
    end
    sd_rd[0] = 1'b1;
    for (int cyc = 0; cyc < 4000 && sb_q.size() > 0; cyc++) begin
      @(negedge CLK);
      if (sd_ack[0]) sd_rd[0] = 1'b0;
      if (mem_rd && !prev_rd && maddr_q.size() > 0) begin
        a = maddr_q.pop_front();
        n_checks++;
        if (mem_addr !== a) begin
          n_fail++; $display("FAIL rd_mem_addr: got %h want %h", mem_addr, a);
        end
      end
      prev_rd = mem_rd;
      if (sd_buff_wr) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({sd_buff_addr, sd_buff_dout} !== {e.addr[8:0], e.data}) begin
          n_fail++;
          $display("FAIL rd_byte: got addr=%0d data=%h want addr=%0d data=%h",
                   sd_buff_addr, sd_buff_dout, e.addr[8:0], e.data);
        end
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL rd_timeout: got %0d bytes pending want 0", sb_q.size());
    end
    for (int cyc = 0; cyc < 20 && sd_ack !== 4'h0; cyc++) @(negedge CLK);
    n_checks++;
    if (sd_ack !== 4'h0) begin
      n_fail++; $display("FAIL rd_ack_fall: got %b want 0000", sd_ack);
    end
  endtask

  task automatic test_write();
    exp_t e;
    logic prev_wr = 1'b0;
    logic rd_seen = 1'b0;
    sb_q.delete();
    sd_lba[1] = 32'd0; sd_blk_cnt[1] = 6'd1; img_size[1] = 20'd368640;
    for (int i = 0; i < 1024; i++) begin
      e.addr = {2'b01, 20'(i)};
      e.data = 8'(i) ^ 8'h5A;
      sb_q.push_back(e);
    end
    sd_wr[1] = 1'b1;
    for (int cyc = 0; cyc < 12000 && sb_q.size() > 0; cyc++) begin
      @(negedge CLK);
      if (sd_ack[1]) sd_wr[1] = 1'b0;
      if (mem_rd || sd_buff_wr) rd_seen = 1'b1;
      if (mem_wr && !prev_wr) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({mem_addr, mem_wdata} !== {e.addr, e.data}) begin
          n_fail++;
          $display("FAIL wr_byte: got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
      prev_wr = mem_wr;
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL wr_timeout: got %0d writes pending want 0", sb_q.size());
    end
    n_checks++;
    if (rd_seen) begin
      n_fail++; $display("FAIL wr_no_read: got read activity want none");
    end
    for (int cyc = 0; cyc < 20 && sd_ack !== 4'h0; cyc++) @(negedge CLK);
    n_checks++;
    if (sd_ack !== 4'h0) begin
      n_fail++; $display("FAIL wr_ack_fall: got %b want 0000", sd_ack);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] prev_ack = 4'h0;
    int         g;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    gnt_q.delete();
    for (int d = 0; d < 4; d++) begin
      sd_lba[d] = 32'(d); sd_blk_cnt[d] = 6'd0; img_size[d] = 20'd368640;
      gnt_q.push_back(d);
    end
    sd_rd = 4'hF;
    for (int cyc = 0; cyc < 12000 && (gnt_q.size() > 0 || sd_ack !== 4'h0); cyc++) begin
      @(negedge CLK);
      n_checks++;
      if (!$onehot0(sd_ack)) begin
        n_fail++; $display("FAIL arb_onehot: got %b want one-hot or zero", sd_ack);
      end
      if (sd_ack != 4'h0 && sd_ack != prev_ack) begin
        n_checks++;
        if (gnt_q.size() == 0) begin
          n_fail++; $display("FAIL arb_extra: got grant %b want none", sd_ack);
        end else begin
          g = gnt_q.pop_front();
          if (sd_ack !== 4'(1 << g)) begin
            n_fail++; $display("FAIL arb_order: got %b want %b", sd_ack, 4'(1 << g));
          end
        end
        sd_rd = sd_rd & ~sd_ack;
      end
      prev_ack = sd_ack;
    end
    if (gnt_q.size() != 0 || sd_ack !== 4'h0) begin
      n_checks++; n_fail++;
      $display("FAIL arb_timeout: got %0d grants pending ack=%b want 0", gnt_q.size(), sd_ack);
    end
    sd_rd = 4'h0;
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic prev_rd = 1'b0;
    int   n_rd = 0;
    sb_q.delete();
    sd_lba[2] = 32'd720; sd_blk_cnt[2] = 6'd0; img_size[2] = 20'd184320;
    for (int i = 0; i < 512; i++) begin
      e.addr = 22'(i); e.data = 8'h00;
      sb_q.push_back(e);
    end
    sd_rd[2] = 1'b1;
    for (int cyc = 0; cyc < 4000 && sb_q.size() > 0; cyc++) begin
      @(negedge CLK);
      if (sd_ack[2]) sd_rd[2] = 1'b0;
      if (mem_rd && !prev_rd) n_rd++;
      prev_rd = mem_rd;
      if (sd_buff_wr) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({sd_buff_addr, sd_buff_dout} !== {e.addr[8:0], e.data}) begin
          n_fail++;
          $display("FAIL oor_byte: got addr=%0d data=%h want addr=%0d data=%h",
                   sd_buff_addr, sd_buff_dout, e.addr[8:0], e.data);
        end
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL oor_timeout: got %0d bytes pending want 0", sb_q.size());
    end
    n_checks++;
    if (n_rd != 0) begin
      n_fail++; $display("FAIL oor_mem_rd: got %0d pulses want 0", n_rd);
    end
    for (int cyc = 0; cyc < 20 && sd_ack !== 4'h0; cyc++) @(negedge CLK);
    n_checks++;
    if (sd_ack !== 4'h0) begin
      n_fail++; $display("FAIL oor_ack_fall: got %b want 0000", sd_ack);
    end
  endtask

  task automatic test_rw_priority();
    exp_t e;
    int   n_wr = 0;
    sb_q.delete();
    sd_lba[3] = 32'd1; sd_blk_cnt[3] = 6'd0; img_size[3] = 20'd368640;
    for (int i = 0; i < 512; i++) begin
      e.addr = 22'(i);
      e.data = 8'((32'h200 + i) & 32'hFF);
      sb_q.push_back(e);
    end
    sd_rd[3] = 1'b1; sd_wr[3] = 1'b1;
    for (int cyc = 0; cyc < 4000 && sb_q.size() > 0; cyc++) begin
      @(negedge CLK);
      if (sd_ack[3]) begin
        sd_rd[3] = 1'b0; sd_wr[3] = 1'b0;
      end
      if (mem_wr) n_wr++;
      if (sd_buff_wr) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({sd_buff_addr, sd_buff_dout} !== {e.addr[8:0], e.data}) begin
          n_fail++;
          $display("FAIL prio_byte: got addr=%0d data=%h want addr=%0d data=%h",
                   sd_buff_addr, sd_buff_dout, e.addr[8:0], e.data);
        end
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL prio_timeout: got %0d bytes pending want 0", sb_q.size());
    end
    n_checks++;
    if (n_wr != 0) begin
      n_fail++; $display("FAIL prio_mem_wr: got %0d cycles want 0", n_wr);
    end
    for (int cyc = 0; cyc < 20 && sd_ack !== 4'h0; cyc++) @(negedge CLK);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   pushes = 0;
    sd_lba[0] = 32'd0; sd_blk_cnt[0] = 6'd0; img_size[0] = 20'd368640;
    sd_rd[0] = 1'b1;
    for (int cyc = 0; cyc < 2000 && pushes < 100; cyc++) begin
      @(negedge CLK);
      if (sd_ack[0]) sd_rd[0] = 1'b0;
      if (sd_buff_wr) pushes++;
    end
    stall = 1'b1;
    for (int cyc = 0; cyc < 20 && mem_rd !== 1'b1; cyc++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    n_checks++;
    if (mem_rd !== 1'b1 || pushes != 100) begin
      n_fail++; $display("FAIL mrst_stalled: got mem_rd=%b pushes=%0d want 1 and 100", mem_rd, pushes);
    end
    // Release the stall together with reset so a ready pulse may land on
    // the reset edge; it must be ignored.
    RESET = 1'b1; stall = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    n_checks++;
    if (sd_ack !== 4'h0) begin
      n_fail++; $display("FAIL mrst_ack: got %b want 0000", sd_ack);
    end
    n_checks++;
    if (mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL mrst_mem_rd: got %b want 0", mem_rd);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL mrst_busy: got %b want 0", busy);
    end
    sb_q.delete();
    sd_lba[0] = 32'd3;
    for (int i = 0; i < 512; i++) begin
      e.addr = 22'(i);
      e.data = 8'((32'h600 + i) & 32'hFF);
      sb_q.push_back(e);
    end
    sd_rd[0] = 1'b1;
    for (int cyc = 0; cyc < 4000 && sb_q.size() > 0; cyc++) begin
      @(negedge CLK);
      if (sd_ack[0]) sd_rd[0] = 1'b0;
      if (sd_buff_wr) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({sd_buff_addr, sd_buff_dout} !== {e.addr[8:0], e.data}) begin
          n_fail++;
          $display("FAIL mrst_fresh: got addr=%0d data=%h want addr=%0d data=%h",
                   sd_buff_addr, sd_buff_dout, e.addr[8:0], e.data);
        end
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL mrst_timeout: got %0d bytes pending want 0", sb_q.size());
    end
    for (int cyc = 0; cyc < 20 && sd_ack !== 4'h0; cyc++) @(negedge CLK);
    n_checks++;
    if (sd_ack !== 4'h0) begin
      n_fail++; $display("FAIL mrst_ack_fall: got %b want 0000", sd_ack);
    end
  endtask

  initial begin
    RESET = 1'b1;
    sd_rd = 4'h0;
    sd_wr = 4'h0;
    for (int d = 0; d < 4; d++) begin
      sd_lba[d]     = 32'd0;
      sd_blk_cnt[d] = 6'd0;
      img_size[d]   = 20'd0;
    end
    test_reset();
    test_read_single();
    test_write();
    test_arbitration();
    test_out_of_range();
    test_rw_priority();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
